// File: rtl/board_input_conditioner.sv
// Board input conditioner: 2-FF synchronise, debounce and pack SW/KEY into GPIO_IN.
// Optional INPUT_KEY0_RESET_EN: debounced KEY[0] press also holds cpu_rst.
module board_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic [17:0] SW,
    input  logic [3:0]  KEY,
    output logic [31:0] GPIO_IN,
    output logic [3:0]  key_press,
    output logic        in_changed,
    output logic        cpu_rst
);

    localparam int NCH   = 22;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1_d, s1_q;
    logic [NCH-1:0]   s2_d, s2_q;
    logic [NCH-1:0]   db_d, db_q;
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [3:0]       key_press_d, key_press_q;
    logic             in_changed_d, in_changed_q;
    logic             cpu_rst_d, cpu_rst_q;

    // Keys are inverted up front so every channel treats 1 as "asserted".
    assign raw = {~KEY, SW};

    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
        db_d = db_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]  = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Strobes look at the next debounced value so they line up with GPIO_IN.
    always_comb begin
        key_press_d  = db_d[21:18] & ~db_q[21:18];
        in_changed_d = |(db_d ^ db_q);
`ifdef INPUT_KEY0_RESET_EN
        cpu_rst_d    = db_d[18];
`else
        cpu_rst_d    = 1'b0;
`endif
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            db_q         <= '0;
            key_press_q  <= '0;
            in_changed_q <= 1'b0;
            cpu_rst_q    <= 1'b1;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            db_q         <= db_d;
            key_press_q  <= key_press_d;
            in_changed_q <= in_changed_d;
            cpu_rst_q    <= cpu_rst_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign GPIO_IN    = {10'b0, db_q};
    assign key_press  = key_press_q;
    assign in_changed = in_changed_q;
    assign cpu_rst    = cpu_rst_q;

endmodule
